// File: rtl/fetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit_if                                                    |
// | Instruction-memory request/response bus between IF and imem.     |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_unit                                                       |
// | MIPS IF stage: PC register, imem request FSM, skid buffer, IF/ID.|
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  wire          clk,
    input  wire          reset,
    input  wire          stall,
    input  wire          boj,
    input  wire   [31:0] npc,
    fetch_unit_if.master imem,
    output logic  [31:0] ir_d,
    output logic  [31:0] pc_d,
    output logic  [31:0] pc8_d,
    output logic         valid_d
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_redir_pc;
    logic        r_redir_pend;
    logic [31:0] r_skid_ir;
    logic [31:0] r_skid_pc;
    logic [31:0] r_ir_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc8_d;
    logic        r_valid_d;

    logic        w_req;
    logic        w_xfer;
    logic        w_redirect;
    logic        w_handoff;
    logic [31:0] w_hand_ir;
    logic [31:0] w_hand_pc;
    logic [31:0] w_next_pc;

    // Request drops combinationally with reset so a late rdy never transfers.
    assign w_req      = (r_state == ST_FETCH) && !reset;
    assign w_xfer     = w_req && imem.imem_rdy;
    assign w_redirect = boj && !stall;
    assign w_handoff  = !stall && (w_xfer || (r_state == ST_HOLD));
    assign w_hand_ir  = (r_state == ST_HOLD) ? r_skid_ir : imem.imem_rdata;
    assign w_hand_pc  = (r_state == ST_HOLD) ? r_skid_pc : r_fetch_pc;

    // A live redirect wins; otherwise a redirect parked behind the delay slot.
    assign w_next_pc  = w_redirect   ? npc        :
                        r_redir_pend ? r_redir_pc :
                                       r_fetch_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_fetch_pc   <= PC_RESET;
            r_redir_pc   <= PC_RESET;
            r_redir_pend <= 1'b0;
            r_skid_ir    <= NOP_WORD;
            r_skid_pc    <= PC_RESET;
            r_ir_d       <= NOP_WORD;
            r_pc_d       <= PC_RESET;
            r_pc8_d      <= PC_RESET + 32'd8;
            r_valid_d    <= 1'b0;
        end else if (w_handoff) begin
            r_ir_d       <= w_hand_ir;
            r_pc_d       <= w_hand_pc;
            r_pc8_d      <= w_hand_pc + 32'd8;
            r_valid_d    <= 1'b1;
            r_fetch_pc   <= w_next_pc;
            r_redir_pend <= 1'b0;
            r_state      <= ST_FETCH;
        end else begin
            if (!stall && (r_state == ST_FETCH)) begin
                r_ir_d    <= NOP_WORD;
                r_valid_d <= 1'b0;
            end
            // Only reachable with stall high: park the word until ID frees up.
            if (w_xfer) begin
                r_skid_ir <= imem.imem_rdata;
                r_skid_pc <= r_fetch_pc;
                r_state   <= ST_HOLD;
            end
            // The word still owed to ID is the delay slot; redirect after it.
            if (w_redirect) begin
                r_redir_pc   <= npc;
                r_redir_pend <= 1'b1;
            end
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fetch_pc;
    assign ir_d           = r_ir_d;
    assign pc_d           = r_pc_d;
    assign pc8_d          = r_pc8_d;
    assign valid_d        = r_valid_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_unit                                                    |
// | Directed vector bench for the IF stage.                          |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
module tb_fetch_unit;

    localparam logic [31:0] C_NOP = 32'h0000_0000;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        boj;
        logic [31:0] npc;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        boj;
    logic [31:0] npc;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;

    int n_cmp;
    int n_bad;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .boj     (boj),
        .npc     (npc),
        .imem    (imem),
        .ir_d    (ir_d),
        .pc_d    (pc_d),
        .pc8_d   (pc8_d),
        .valid_d (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    function automatic vec_t mk(input logic rst, input logic stl, input logic bj,
                                input logic [31:0] tgt, input logic rdy,
                                input logic req, input logic [31:0] addr,
                                input logic vld, input logic [31:0] pc);
        vec_t v;
        v.rst = rst;  v.stall = stl;  v.boj = bj;  v.npc = tgt;  v.rdy = rdy;
        v.exp_req = req;  v.exp_addr = addr;  v.exp_valid = vld;  v.exp_pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive at negedge, check the request side before the edge, IF/ID after it.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] exp_ir;
        @(negedge clk);
        reset = v.rst;
        stall = v.stall;
        boj   = v.boj;
        npc   = v.npc;
        imem.imem_rdy   = v.rdy;
        imem.imem_rdata = v.exp_req ? mem_word(v.exp_addr) : 32'hBAD0_BAD0;
        #1;
        chk({tag, ".req"},  {31'd0, imem.imem_req}, {31'd0, v.exp_req});
        chk({tag, ".addr"}, imem.imem_addr, v.exp_addr);
        @(posedge clk);
        #1;
        exp_ir = v.exp_valid ? mem_word(v.exp_pc) : C_NOP;
        chk({tag, ".valid"}, {31'd0, valid_d}, {31'd0, v.exp_valid});
        chk({tag, ".pc"},    pc_d,  v.exp_pc);
        chk({tag, ".pc8"},   pc8_d, v.exp_pc + 32'd8);
        chk({tag, ".ir"},    ir_d,  exp_ir);
    endtask

    vec_t vecs[$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        stall = 1'b0;
        boj   = 1'b0;
        npc   = 32'd0;
        imem.imem_rdy   = 1'b0;
        imem.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);

        //            rst stl boj npc           rdy req addr          vld pc
        // reset state, straight-line fetch, taken branch at 3004
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0000_3000, 0, 32'h0000_3000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3000, 1, 32'h0000_3000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3004, 1, 32'h0000_3004));
        vecs.push_back(mk(0, 0, 1, 32'h3100,     1, 1, 32'h0000_3008, 1, 32'h0000_3008));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3100, 1, 32'h0000_3100));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3104, 1, 32'h0000_3104));
        // slow memory with a branch while the delay slot is outstanding
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0000_3108, 0, 32'h0000_3000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3000, 1, 32'h0000_3000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3004, 1, 32'h0000_3004));
        vecs.push_back(mk(0, 0, 1, 32'h3200,     0, 1, 32'h0000_3008, 0, 32'h0000_3004));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_3008, 0, 32'h0000_3004));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3008, 1, 32'h0000_3008));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3200, 1, 32'h0000_3200));
        // stall while the word arrives: skid buffer, late rdy ignored in HOLD
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 1, 32'h0000_3204, 1, 32'h0000_3200));
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 0, 32'h0000_3204, 1, 32'h0000_3200));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 32'h0000_3204, 1, 32'h0000_3200));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0000_3204, 1, 32'h0000_3204));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3208, 1, 32'h0000_3208));
        // stall holds IF/ID, no-rdy without stall bubbles, stall holds the bubble
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h0000_320C, 1, 32'h0000_3208));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_320C, 0, 32'h0000_3208));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 1, 32'h0000_320C, 0, 32'h0000_3208));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_320C, 1, 32'h0000_320C));
        // boj under stall ignored, then taken once stall drops (from HOLD)
        vecs.push_back(mk(0, 1, 1, 32'h3400,     1, 1, 32'h0000_3210, 1, 32'h0000_320C));
        vecs.push_back(mk(0, 0, 1, 32'h3400,     0, 0, 32'h0000_3210, 1, 32'h0000_3210));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3400, 1, 32'h0000_3400));
        vecs.push_back(mk(0, 1, 1, 32'h3500,     0, 1, 32'h0000_3404, 1, 32'h0000_3400));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3404, 1, 32'h0000_3404));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3408, 1, 32'h0000_3408));
        // reset mid-fetch with rdy in the same cycle
        vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0000_340C, 0, 32'h0000_3000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_3000, 0, 32'h0000_3000));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_3000, 1, 32'h0000_3000));
        // redirect to the top word, PC wraps to zero
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h0000_3004, 1, 32'h0000_3004));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC));
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_0000, 1, 32'h0000_0000));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // long latency: address must stay put and ID sees bubbles until rdy
        for (int k = 0; k < 4; k++)
            apply(mk(0, 0, 0, 32'h0, 0, 1, 32'h0000_0004, 0, 32'h0000_0000),
                  $sformatf("wait%0d", k));
        apply(mk(0, 0, 0, 32'h0, 1, 1, 32'h0000_0004, 1, 32'h0000_0004), "wait_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
